// File: rtl/ef_seq_if.sv
// Bundles the e/f monitor inputs and its status outputs.
// The testbench drives the master side and the monitor sits on the slave side.
interface ef_seq_if #(
    parameter int CNT_W = 8
);
    logic             e_in;
    logic             f_in;
    logic             clr;
    logic [CNT_W-1:0] e_rise_cnt;
    logic [CNT_W-1:0] f_rise_cnt;
    logic             match;
    logic             timeout;
    logic             busy;

    modport master (
        output e_in,
        output f_in,
        output clr,
        input  e_rise_cnt,
        input  f_rise_cnt,
        input  match,
        input  timeout,
        input  busy
    );

    modport slave (
        input  e_in,
        input  f_in,
        input  clr,
        output e_rise_cnt,
        output f_rise_cnt,
        output match,
        output timeout,
        output busy
    );
endinterface

// File: rtl/ef_seq_monitor.sv
// Watches the registered e/f pair: counts rising edges and checks that every
// e rise is followed by an f rise within WINDOW cycles.
module ef_seq_monitor #(
    parameter int CNT_W  = 8,
    parameter int WINDOW = 4
) (
    input  logic    clk,
    input  logic    rst,
    ef_seq_if.slave bus
);
    localparam int              WC_W     = $clog2(WINDOW + 1);
    localparam logic [WC_W-1:0] WIN_LOAD = WC_W'(WINDOW);
    localparam logic [WC_W-1:0] WC_ONE   = WC_W'(1);
    localparam logic [WC_W-1:0] WC_ZERO  = {WC_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic en);
        logic [CNT_W-1:0] r;
        if (en && (v != CNT_MAX)) begin
            r = v + CNT_ONE;
        end else begin
            r = v;
        end
        return r;
    endfunction

    logic             e_q_r;
    logic             f_q_r;
    logic [CNT_W-1:0] e_cnt_r;
    logic [CNT_W-1:0] f_cnt_r;
    logic             match_r;
    logic             timeout_r;
    logic             busy_r;
    state_t           state_r;
    logic [WC_W-1:0]  wait_cnt_r;

    logic             e_rise_s;
    logic             f_rise_s;
    state_t           state_nxt_s;
    logic [WC_W-1:0]  wait_cnt_nxt_s;
    logic             match_nxt_s;
    logic             timeout_nxt_s;

    assign e_rise_s = bus.e_in & ~e_q_r;
    assign f_rise_s = bus.f_in & ~f_q_r;

    // Next-state and pulse decode for the IDLE/WAIT ordering checker.
    always_comb begin
        state_nxt_s    = state_r;
        wait_cnt_nxt_s = wait_cnt_r;
        match_nxt_s    = 1'b0;
        timeout_nxt_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (e_rise_s && f_rise_s) begin
                    match_nxt_s = 1'b1;
                end else if (e_rise_s) begin
                    state_nxt_s    = ST_WAIT;
                    wait_cnt_nxt_s = WIN_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (f_rise_s && e_rise_s) begin
                    // f closes the old window while e opens a fresh one.
                    match_nxt_s    = 1'b1;
                    wait_cnt_nxt_s = WIN_LOAD;
                end else if (f_rise_s) begin
                    match_nxt_s    = 1'b1;
                    state_nxt_s    = ST_IDLE;
                    wait_cnt_nxt_s = WC_ZERO;
                end else if (e_rise_s) begin
                    wait_cnt_nxt_s = WIN_LOAD;
                end else if (wait_cnt_r <= WC_ONE) begin
                    timeout_nxt_s  = 1'b1;
                    state_nxt_s    = ST_IDLE;
                    wait_cnt_nxt_s = WC_ZERO;
                end else begin
                    wait_cnt_nxt_s = wait_cnt_r - WC_ONE;
                end
            end
            default: begin
                state_nxt_s    = ST_IDLE;
                wait_cnt_nxt_s = WC_ZERO;
            end
        endcase
    end

    // State, counters and registered outputs; the edge samplers keep running
    // through clr so a level held across clr is not seen as a new rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            e_q_r      <= 1'b0;
            f_q_r      <= 1'b0;
            e_cnt_r    <= {CNT_W{1'b0}};
            f_cnt_r    <= {CNT_W{1'b0}};
            match_r    <= 1'b0;
            timeout_r  <= 1'b0;
            busy_r     <= 1'b0;
            state_r    <= ST_IDLE;
            wait_cnt_r <= WC_ZERO;
        end else begin
            e_q_r <= bus.e_in;
            f_q_r <= bus.f_in;
            if (bus.clr) begin
                e_cnt_r    <= {CNT_W{1'b0}};
                f_cnt_r    <= {CNT_W{1'b0}};
                match_r    <= 1'b0;
                timeout_r  <= 1'b0;
                busy_r     <= 1'b0;
                state_r    <= ST_IDLE;
                wait_cnt_r <= WC_ZERO;
            end else begin
                e_cnt_r    <= sat_inc(e_cnt_r, e_rise_s);
                f_cnt_r    <= sat_inc(f_cnt_r, f_rise_s);
                match_r    <= match_nxt_s;
                timeout_r  <= timeout_nxt_s;
                busy_r     <= (state_nxt_s == ST_WAIT);
                state_r    <= state_nxt_s;
                wait_cnt_r <= wait_cnt_nxt_s;
            end
        end
    end

    assign bus.e_rise_cnt = e_cnt_r;
    assign bus.f_rise_cnt = f_cnt_r;
    assign bus.match      = match_r;
    assign bus.timeout    = timeout_r;
    assign bus.busy       = busy_r;
endmodule
